// File: rtl/nic_pkg.sv
// Shared constants for the NIC: register map, packet geometry, channel indices.
package nic_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int VC_BIT     = 63;

    // Processor-visible register map
    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Index of each packet channel in the top-level channel arrays
    localparam int NUM_CH = 2;
    localparam int CH_OUT = 0;
    localparam int CH_IN  = 1;

endpackage

// File: rtl/nic_buffer.sv
// Single-entry packet buffer with full flag. A load always wins over a clear,
// so a refill in the same cycle as a drain keeps the new packet.
module nic_buffer #(
    parameter int DATA_WIDTH = nic_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  full_reg;

    // Capture the packet on load, drop the full flag on clear; reset empties at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= d;
            full_reg <= 1'b1;
        end else if (clear) begin
            full_reg <= 1'b0;
        end
    end

    assign q    = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/nic.sv
// Network interface controller: four-register processor window in front of
// one outbound and one inbound single-entry packet buffer. Outbound packets
// leave only in a cycle whose router polarity equals the packet's VC bit.
module nic #(
    parameter int DATA_WIDTH = nic_pkg::DATA_WIDTH,
    parameter int VC_BIT     = nic_pkg::VC_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  polarity,
    output logic                  net_si,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_ri,
    input  logic                  net_so,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_ro
);

    import nic_pkg::ADDR_IN_DATA;
    import nic_pkg::ADDR_IN_STAT;
    import nic_pkg::ADDR_OUT_DATA;
    import nic_pkg::ADDR_OUT_STAT;
    import nic_pkg::NUM_CH;
    import nic_pkg::CH_OUT;
    import nic_pkg::CH_IN;

    logic [DATA_WIDTH-1:0] ch_d     [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_q     [NUM_CH];
    logic                  ch_load  [NUM_CH];
    logic                  ch_clear [NUM_CH];
    logic                  ch_full  [NUM_CH];

    logic                  out_full;
    logic                  in_full;
    logic [DATA_WIDTH-1:0] out_buf;
    logic [DATA_WIDTH-1:0] in_buf;
    logic                  wr_out_data;
    logic                  rd_in_data;

    // One buffer per direction; both share the same load/clear semantics
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            nic_buffer #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_buf (
                .clk   (clk),
                .reset (reset),
                .load  (ch_load[gi]),
                .clear (ch_clear[gi]),
                .d     (ch_d[gi]),
                .q     (ch_q[gi]),
                .full  (ch_full[gi])
            );
        end
    endgenerate

    assign out_full = ch_full[CH_OUT];
    assign in_full  = ch_full[CH_IN];
    assign out_buf  = ch_q[CH_OUT];
    assign in_buf   = ch_q[CH_IN];

    // Processor access decode
    assign wr_out_data = nicEn &  nicEnWr & (addr == ADDR_OUT_DATA);
    assign rd_in_data  = nicEn & ~nicEnWr & (addr == ADDR_IN_DATA);

    // Outbound: a write into a full buffer is dropped; injection needs a
    // ready router and a polarity that matches the packet's VC bit
    assign net_si           = out_full & net_ri & (out_buf[VC_BIT] == polarity);
    assign ch_d[CH_OUT]     = d_in;
    assign ch_load[CH_OUT]  = wr_out_data & ~out_full;
    assign ch_clear[CH_OUT] = net_si;
    assign net_do           = out_buf;

    // Inbound: ready depends only on the registered full flag, so there is
    // no combinational path from net_so back to net_ro
    assign net_ro          = ~in_full;
    assign ch_d[CH_IN]     = net_di;
    assign ch_load[CH_IN]  = net_so & net_ro;
    assign ch_clear[CH_IN] = rd_in_data & in_full;

    // Processor read mux; everything reads as zero while the window is disabled
    always_comb begin
        d_out = '0;
        if (nicEn) begin
            unique case (addr)
                ADDR_IN_DATA:  d_out = in_buf;
                ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_DATA: d_out = '0;
                ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out = '0;
            endcase
        end
    end

endmodule

// File: doc/nic.md
# nic

Network interface controller between a processing element and the PE port of one mesh router. The processor side is a four-register load/store window. The network side has two 64-bit packet channels, each with a single-entry buffer. Injection obeys the router's even/odd virtual-channel polarity, so a packet leaves only in a cycle whose polarity matches its VC bit.

## Interface
- DATA_WIDTH, 64, packet and processor data width.
- VC_BIT, 63, packet bit index holding the virtual channel.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- addr  in  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_WIDTH  processor write data.
- d_out  out  DATA_WIDTH  processor read data; combinational.
- nicEn  in  1  processor access enable.
- nicEnWr  in  1  1 = write, 0 = read; qualified by nicEn.
- polarity  in  1  router polarity (0 even, 1 odd); toggles each cycle.
- net_si  out  1  send request to router PE input.
- net_do  out  DATA_WIDTH  packet to router PE input.
- net_ri  in  1  router PE input ready.
- net_so  in  1  router PE output has a packet.
- net_di  in  DATA_WIDTH  packet from router PE output.
- net_ro  out  1  NIC ready to accept a packet.

## Operation
- State: out_buf plus out_full; in_buf plus in_full. All zero on reset.
- Processor write, when nicEn & nicEnWr & addr==10 & !out_full:
  - out_buf <= d_in and out_full <= 1.
  - If out_full=1 the write is dropped silently.
  - Writes to any other address are ignored.
- Processor read of input data, when nicEn & !nicEnWr & addr==00:
  - d_out = in_buf, and in_full <= 0 at the edge.
  - If in_full=0, d_out = in_buf (stale) and nothing changes.
- d_out mapping:
  - 01 gives {63'b0, in_full}.
  - 11 gives {63'b0, out_full}.
  - 10 gives 0.
  - d_out = 0 whenever nicEn=0.
- Injection: net_si = out_full & net_ri & (out_buf[VC_BIT]==polarity). On a posedge with net_si=1, out_full <= 0.
- net_do = out_buf at all times.
- Ejection: net_ro = !in_full. On a posedge with net_so & net_ro, in_buf <= net_di and in_full <= 1.
- Simultaneous events:
  - Injection and a processor write in the same cycle: the write is dropped, since out_full is still 1 when sampled.
  - Ejection and a processor read of input data in the same cycle: cannot both take effect, because net_ro=0 while in_full=1. The read empties the buffer, so the earliest refill is at the next edge.
- Reset mid-packet: buffers empty immediately and asynchronously, and any partially handshaken packet is lost.

## Timing
- Reset values:
  - net_si 0, net_do 0, d_out 0.
  - net_ro 1, since in_full=0.
- Write-to-inject latency: a write sampled at edge N sets out_full after N. Injection happens at edge N+1 if polarity matches the VC bit, else at edge N+2, provided net_ri=1.
- Eject-to-visible latency: a packet captured at edge N shows input status 1 and readable data in the cycle after N.
- Throughput per direction: 1 packet per 2 cycles at best, because of polarity matching and single-entry buffers.
- net_si and net_ro are combinational from registered state and inputs. No combinational path from net_so to net_ro.

## Structure
- Package nic_pkg holds:
  - address constants ADDR_IN_DATA=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_DATA=2'b10, ADDR_OUT_STAT=2'b11;
  - VC_BIT.
- Sub-module nic_buffer: one-entry DATA_WIDTH register with full flag, load/clear strobes and async reset. Instantiated twice, once as the output channel and once as the input channel.
- nic top holds the address decode, the d_out mux, and the polarity/handshake logic.

## Test plan
- Reset mid-traffic: assert reset with both buffers full -> net_si=0, net_ro=1, and status reads return 0 after release.
- Injection with polarity match: write 64'h8000_0000_0000_00AA while polarity=1 next cycle and net_ri=1 -> net_si=1 exactly one cycle, net_do=64'h8000_0000_0000_00AA, and output status reads 0 afterwards.
- Injection polarity mismatch and backpressure: packet with VC=0, net_ri held 0 for 5 cycles -> net_si=0 throughout. After net_ri rises, net_si=1 only on the first polarity=0 cycle.
- Ejection and read: net_so=1 with net_di=64'h1234 -> net_ro drops to 0 and input status reads 1. Reading addr 00 returns 64'h1234, then net_ro=1 and status reads 0.
- Full-buffer write drop: two back-to-back writes, 64'h1 then 64'h2, with net_ri=0 -> net_do stays 64'h1.
- Ejection backpressure: a second net_so while in_full=1 -> not captured; in_buf keeps the first packet until it is read.
